// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : gshare back end - carries branch records ID->EX->MEM, resolves in
//            EX, trains the predictor in MEM, redirects and squashes on miss.
//            Optional BRU_STATS_EN adds saturating branch/mispredict counters.
// Revision : 1.0
// ============================================================================
module branch_resolve_unit #(
    parameter int PHT_IDX_W     = 3,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 id_valid,
    input  logic                 id_pred_taken,
    input  logic [PHT_IDX_W-1:0] id_pht_index,
    input  logic [31:0]          id_pc,
    input  logic [31:0]          id_imm,
    input  logic [2:0]           id_funct3,
    input  logic [31:0]          ex_rs1_val,
    input  logic [31:0]          ex_rs2_val,
    output logic                 branch_resolved,
    output logic                 actual_taken,
    output logic [PHT_IDX_W-1:0] pht_indexMEM,
    output logic                 mispredict,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [1:0]           flush
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
`endif
);

    localparam logic [2:0] c_squash_load = SQUASH_CYCLES[2:0];

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;

    logic                 r_ex_valid;
    logic                 r_ex_pred;
    logic [PHT_IDX_W-1:0] r_ex_idx;
    logic [31:0]          r_ex_pc;
    logic [31:0]          r_ex_imm;
    logic [2:0]           r_ex_funct3;

    logic                 r_resolved;
    logic                 r_mem_taken;
    logic [PHT_IDX_W-1:0] r_mem_idx;
    logic                 r_mem_mispred;
    logic [31:0]          r_mem_target;

    logic        w_redirect;
    logic        w_accept;
    logic        w_promote;
    logic        w_taken;
    logic        w_mispred;
    logic [31:0] w_target;

    assign w_redirect = (r_state == ST_REDIRECT);
    // Wrong-path records are never captured outside IDLE; the EX entry is killed during REDIRECT.
    assign w_accept   = id_valid & ~stall & (r_state == ST_IDLE);
    assign w_promote  = r_ex_valid & ~stall & ~w_redirect;

    always_comb begin
        w_taken = 1'b0;
        case (r_ex_funct3)
            3'b000:  w_taken = (ex_rs1_val == ex_rs2_val);
            3'b001:  w_taken = (ex_rs1_val != ex_rs2_val);
            3'b100:  w_taken = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
            3'b101:  w_taken = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
            3'b110:  w_taken = (ex_rs1_val <  ex_rs2_val);
            3'b111:  w_taken = (ex_rs1_val >= ex_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_target  = w_taken ? (r_ex_pc + r_ex_imm) : (r_ex_pc + 32'd4);
    assign w_mispred = (w_taken != r_ex_pred);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_promote && w_mispred) w_state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                // Leaves after one cycle even under stall.
                w_state_nxt = ST_SQUASH;
                w_cnt_nxt   = c_squash_load;
            end
            ST_SQUASH: begin
                if (!stall) begin
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_pred   <= 1'b0;
            r_ex_idx    <= '0;
            r_ex_pc     <= 32'd0;
            r_ex_imm    <= 32'd0;
            r_ex_funct3 <= 3'd0;
        end else begin
            if (w_redirect) begin
                r_ex_valid <= 1'b0;
            end else if (!stall) begin
                r_ex_valid <= w_accept;
            end
            if (w_accept) begin
                r_ex_pred   <= id_pred_taken;
                r_ex_idx    <= id_pht_index;
                r_ex_pc     <= id_pc;
                r_ex_imm    <= id_imm;
                r_ex_funct3 <= id_funct3;
            end
        end
    end

    // r_resolved is rewritten every edge so a held MEM entry pulses only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resolved    <= 1'b0;
            r_mem_taken   <= 1'b0;
            r_mem_idx     <= '0;
            r_mem_mispred <= 1'b0;
            r_mem_target  <= 32'd0;
        end else begin
            r_resolved <= w_promote;
            if (w_promote) begin
                r_mem_taken   <= w_taken;
                r_mem_idx     <= r_ex_idx;
                r_mem_mispred <= w_mispred;
                r_mem_target  <= w_target;
            end
        end
    end

    assign branch_resolved = r_resolved;
    assign actual_taken    = r_mem_taken;
    assign pht_indexMEM    = r_mem_idx;
    assign mispredict      = r_mem_mispred;
    assign redirect_valid  = w_redirect;
    assign redirect_pc     = w_redirect ? r_mem_target : 32'd0;
    assign flush           = w_redirect ? 2'b11 : 2'b00;

`ifdef BRU_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br  <= 32'd0;
            r_stat_mis <= 32'd0;
        end else if (w_promote) begin
            if (r_stat_br != 32'hFFFF_FFFF) r_stat_br <= r_stat_br + 32'd1;
            if (w_mispred && (r_stat_mis != 32'hFFFF_FFFF)) r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;
`endif

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Back end of the gshare branch path. Captures each conditional branch's prediction record from ID (predicted direction, PHT index, PC, immediate) and carries it through its own ID/EX and EX/MEM registers.
- Evaluates the condition in EX and issues the one-cycle MEM-stage resolution (branch_resolved, actual_taken, pht_indexMEM) that the predictor consumes for PHT/GHR training.
- On a misprediction, drives the redirect PC and flush to the front end and squashes wrong-path branch records.

Parameters:
- PHT_IDX_W, 3, width of the PHT index carried with each branch (matches GHR width).
- SQUASH_CYCLES, 2, cycles after a redirect during which incoming ID branch records are discarded (wrong-path drain); legal range 1..7.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline hold; freezes both internal stage registers and the FSM.
- id_valid  in  1  conditional branch present in ID this cycle.
- id_pred_taken  in  1  predictor's direction for that branch.
- id_pht_index  in  PHT_IDX_W  PHT index used for the prediction.
- id_pc  in  32  branch PC.
- id_imm  in  32  sign-extended B-type offset.
- id_funct3  in  3  branch condition code.
- ex_rs1_val  in  32  forwarded rs1 value, valid in the EX cycle.
- ex_rs2_val  in  32  forwarded rs2 value, valid in the EX cycle.
- branch_resolved  out  1  one-cycle MEM-stage resolution pulse.
- actual_taken  out  1  resolved direction, qualified by branch_resolved.
- pht_indexMEM  out  PHT_IDX_W  PHT index of the resolving branch.
- mispredict  out  1  resolved direction differs from prediction.
- redirect_valid  out  1  front end must load redirect_pc.
- redirect_pc  out  32  correct next PC.
- flush  out  2  2'b11 flushes IF/ID and ID/EX during a redirect, else 2'b00.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0. Both stage-valid bits cleared. FSM in IDLE. Squash counter 0.
  - Takes effect immediately, even mid-redirect or mid-squash.
- Pipeline and latency:
  - A branch accepted on edge E (id_valid=1, !stall, not squashed) is in EX during cycle E+1.
  - It is compared in that cycle and registered so that branch_resolved=1 during cycle E+2.
  - Fixed latency of 2 cycles from ID to resolution when there is no stall.
- Compare (EX, 32-bit):
  - 000 BEQ (eq), 001 BNE (ne), 100 BLT (signed <), 101 BGE (signed >=), 110 BLTU (unsigned <), 111 BGEU (unsigned >=).
  - 010 and 011 resolve as not taken.
- Target:
  - taken: pc+imm, modulo 2^32 (wrap-around, no overflow flag).
  - not taken: pc+4.
  - redirect_pc is the target for the actual direction.
- branch_resolved is a pulse:
  - Asserted exactly one cycle per branch.
  - Not re-asserted while stall holds the MEM register.
  - actual_taken, pht_indexMEM and mispredict hold their values until the next resolution.
- FSM: IDLE, REDIRECT, SQUASH.
  - IDLE -> REDIRECT when a resolving branch mispredicts. REDIRECT is entered in the same cycle branch_resolved rises.
  - REDIRECT lasts exactly 1 cycle: redirect_valid=1, flush=2'b11.
  - Any valid EX entry in that cycle is wrong path. It is killed and never resolves.
  - REDIRECT -> SQUASH, counter loaded with SQUASH_CYCLES.
  - In SQUASH: id_valid is ignored and the counter decrements each unstalled cycle. SQUASH -> IDLE when the counter reaches 0.
  - A correctly predicted resolution never leaves IDLE.
- Stall:
  - Freezes the stage registers, counter and FSM state.
  - Does not extend the redirect pulse: redirect_valid and flush still drop after one cycle.
- Simultaneous events:
  - Mispredict in MEM, branch in EX and new id_valid in the same cycle: the EX entry is killed and the ID capture is suppressed.
  - stall together with a mispredict: the redirect still fires.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each branch_resolved; stat_mispredicts on each mispredict resolution.
  - Both saturate at 32'hFFFFFFFF and are cleared by rst_n.
- When undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- BEQ, rs1=rs2=5, pred_taken=0, pc=0x100, imm=0x20, pht_index=3'b101 -> cycle+2: branch_resolved=1, actual_taken=1, pht_indexMEM=101, mispredict=1, redirect_valid=1, redirect_pc=0x120, flush=2'b11 for 1 cycle.
- BLTU, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> actual_taken=0, mispredict=0, no redirect, FSM stays IDLE. BLT with the same operands -> actual_taken=1.
- Back-to-back branches: the first mispredicts, the second is in EX -> the second never pulses branch_resolved. An id_valid during the 2 SQUASH cycles is ignored; the first id_valid after that resolves normally.
- stall held 3 cycles with a branch in MEM -> exactly one branch_resolved pulse. redirect_valid is 1 cycle; outputs hold.
- pc=0xFFFFFFF0, imm=0x20, taken mispredict -> redirect_pc=0x00000010. rst_n low during REDIRECT -> all outputs 0 asynchronously and FSM in IDLE.
- BRU_STATS_EN: 10 branches, 3 mispredicted -> stat_branches=10, stat_mispredicts=3. Counter forced near max saturates at 0xFFFFFFFF.
